// File: rtl/operand_stage_pkg.sv
// operand_stage shared types and constants.
// Widths, opcodes, skid-buffer states, entry bundle.
package operand_stage_pkg;

  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int OPW  = 2;
  localparam int NREG = 1 << AW;

  localparam logic [OPW-1:0] OP_ADD = 2'b00;
  localparam logic [OPW-1:0] OP_SUB = 2'b01;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_t;

  typedef struct packed {
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [OPW-1:0] op;
    logic [AW-1:0]  rd;
  } entry_t;

endpackage

// File: rtl/operand_stage_if.sv
// operand_stage bus: issue side, ALU side, write-back.
// master = upstream/testbench, slave = the stage.
interface operand_stage_if;
  import operand_stage_pkg::*;

  logic           In_valid;
  logic           In_ready;
  logic [AW-1:0]  RsA;
  logic [AW-1:0]  RsB;
  logic [DW-1:0]  Imm;
  logic           UseImm;
  logic [OPW-1:0] OpIn;
  logic [AW-1:0]  Rd;
  logic           Out_valid;
  logic           Out_ready;
  logic [DW-1:0]  InputA;
  logic [DW-1:0]  InputB;
  logic [OPW-1:0] OP;
  logic [AW-1:0]  RdOut;
  logic           WrEn;
  logic [AW-1:0]  WrAddr;
  logic [DW-1:0]  WrData;

  modport master (
    output In_valid, RsA, RsB, Imm, UseImm,
    output OpIn, Rd, Out_ready,
    output WrEn, WrAddr, WrData,
    input  In_ready, Out_valid,
    input  InputA, InputB, OP, RdOut
  );

  modport slave (
    input  In_valid, RsA, RsB, Imm, UseImm,
    input  OpIn, Rd, Out_ready,
    input  WrEn, WrAddr, WrData,
    output In_ready, Out_valid,
    output InputA, InputB, OP, RdOut
  );

endinterface

// File: rtl/operand_stage_reg_file.sv
// 8x8 register file, reg[0] hardwired to zero.
// Two read ports with same-cycle write bypass.
module reg_file
  import operand_stage_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  output logic [DW-1:0] da,
  output logic [DW-1:0] db,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] regs [NREG];
  logic          wr_ok;

  assign wr_ok = wr_en && (wr_addr != '0);

  // write port; index 0 is never written
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // read ports: zero index, then bypass, then array
  always_comb begin
    da = regs[ra];
    db = regs[rb];
    if (ra == '0)
      da = '0;
    else if (wr_ok && wr_addr == ra)
      da = wr_data;
    if (rb == '0)
      db = '0;
    else if (wr_ok && wr_addr == rb)
      db = wr_data;
  end

endmodule

// File: rtl/operand_stage.sv
// Operand fetch: reg file read, imm mux for B,
// two-entry skid buffer feeding the ALU.
module operand_stage
  import operand_stage_pkg::*;
(
  input  logic      Clk,
  input  logic      Reset_n,
  operand_stage_if.slave bus
);

  state_t        state;
  state_t        state_nxt;
  entry_t        head;
  entry_t        skid;
  entry_t        in_e;
  logic [DW-1:0] rf_a;
  logic [DW-1:0] rf_b;
  logic          accept;
  logic          drain;
  logic          ld_head_in;
  logic          ld_head_skid;
  logic          ld_skid;

  reg_file u_rf (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .ra      (bus.RsA),
    .rb      (bus.RsB),
    .da      (rf_a),
    .db      (rf_b),
    .wr_en   (bus.WrEn),
    .wr_addr (bus.WrAddr),
    .wr_data (bus.WrData)
  );

  assign in_e.a  = rf_a;
  assign in_e.b  = bus.UseImm ? bus.Imm : rf_b;
  assign in_e.op = bus.OpIn;
  assign in_e.rd = bus.Rd;

  // handshake flags decoded straight from state
  assign bus.In_ready  = (state != ST_TWO);
  assign bus.Out_valid = (state != ST_EMPTY);

  assign accept = bus.In_valid & bus.In_ready;
  assign drain  = bus.Out_valid & bus.Out_ready;

  // state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= ST_EMPTY;
    else          state <= state_nxt;
  end

  // next state and buffer load controls
  always_comb begin
    state_nxt    = state;
    ld_head_in   = 1'b0;
    ld_head_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt  = ST_ONE;
          ld_head_in = 1'b1;
        end
      end
      ST_ONE: begin
        unique case (1'b1)
          accept && drain: begin
            ld_head_in = 1'b1;
          end
          accept && !drain: begin
            state_nxt = ST_TWO;
            ld_skid   = 1'b1;
          end
          !accept && drain: begin
            state_nxt = ST_EMPTY;
          end
          default: ;
        endcase
      end
      ST_TWO: begin
        if (drain) begin
          state_nxt    = ST_ONE;
          ld_head_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // head and skid storage
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (ld_head_in)        head <= in_e;
      else if (ld_head_skid) head <= skid;
      if (ld_skid)           skid <= in_e;
    end
  end

  assign bus.InputA = head.a;
  assign bus.InputB = head.b;
  assign bus.OP     = head.op;
  assign bus.RdOut  = head.rd;

endmodule
